// File: rtl/shift_sequencer_16bit.sv
// Multi-pass rotate sequencer: one command in, its word fed back through one 16-bit rotator once per clock,
// result after in_count cycles (0 = next cycle), held on out_* until out_ready; no command accepted meanwhile.

module shift_stage_16bit (
    input  logic [15:0] a,
    input  logic [3:0]  amt,
    input  logic        choice,
    output logic [15:0] y
);
    logic [31:0] w_dbl;
    logic [31:0] w_left;
    logic [31:0] w_right;

    // Doubling the word turns a rotate into a plain shift of the concatenation.
    assign w_dbl   = {a, a};
    assign w_left  = w_dbl << amt;
    assign w_right = w_dbl >> amt;
    assign y       = choice ? w_right[15:0] : w_left[31:16];
endmodule

module shift_sequencer_16bit #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [3:0]       in_amt,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_acc;
    logic [3:0]       r_amt;
    logic             r_dir;
    logic [CNT_W-1:0] r_rem;
    logic [15:0]      w_stage;
    logic             w_accept;
    logic             w_last_pass;

    shift_stage_16bit u_stage (
        .a      (r_acc),
        .amt    (r_amt),
        .choice (r_dir),
        .y      (w_stage)
    );

    assign w_accept    = (r_state == ST_IDLE) && in_valid;
    // rem is never 0 in RUN; treating 0 like 1 keeps a corrupted count from wrapping.
    assign w_last_pass = (r_rem <= CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (in_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_pass) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_RUN:  busy      = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= 16'h0000;
            r_amt <= 4'd0;
            r_dir <= 1'b0;
            r_rem <= '0;
        end else if (w_accept) begin
            r_acc <= in_data;
            r_amt <= in_amt;
            r_dir <= in_dir;
            r_rem <= in_count;
        end else if (r_state == ST_RUN) begin
            r_acc <= w_stage;
            if (r_rem != '0) begin
                r_rem <= r_rem - CNT_W'(1);
            end
        end
    end

    assign out_data = r_acc;
endmodule

// File: tb/tb_shift_sequencer_16bit.sv
module tb_shift_sequencer_16bit;
    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic        in_dir;
    logic [3:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp;

    shift_sequencer_16bit #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rot_model(input logic [15:0] d, input int amt,
                                              input logic dir, input int cnt);
        logic [15:0] r;
        int          n;
        r = d;
        n = (amt * cnt) % 16;
        for (int i = 0; i < n; i++) begin
            if (dir) r = {r[0], r[15:1]};
            else     r = {r[14:0], r[15]};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1 while IDLE; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [3:0] a, input logic dir, input logic [3:0] cnt);
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        in_count = cnt;
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(rot_model(d, int'(a), dir, int'(cnt)));
    endtask

    task automatic wait_result(input string tag, input int cnt);
        int cycles;
        int busy_cnt;
        cycles   = 0;
        busy_cnt = 0;
        while (!out_valid && cycles < 40) begin
            if (busy) busy_cnt++;
            check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
            in_data  = 16'($urandom);
            in_amt   = 4'($urandom);
            in_dir   = 1'($urandom);
            in_count = 4'($urandom);
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(cnt));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(cnt));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
            last_exp = 16'hxxxx;
        end else begin
            last_exp = exp_q.pop_front();
        end
        check({tag, "_data"}, 32'(out_data), 32'(last_exp));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_amt    = 4'd0;
        in_dir    = 1'b0;
        in_count  = 4'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'h8001, 4'd1, 1'b0, 4'd1);
        wait_result("single", 1);
        check("single_literal", 32'(out_data), 32'h0003);
        drain("single");

        send(16'h1234, 4'd4, 1'b1, 4'd3);
        wait_result("right3", 3);
        check("right3_literal", 32'(out_data), 32'h2341);
        drain("right3");

        send(16'hBEEF, 4'd7, 1'b0, 4'd0);
        wait_result("passthru", 0);
        check("passthru_literal", 32'(out_data), 32'hBEEF);
        drain("passthru");

        send(16'hA5C3, 4'd0, 1'b1, 4'd15);
        wait_result("amt0_cnt15", 15);
        check("amt0_cnt15_literal", 32'(out_data), 32'hA5C3);
        drain("amt0_cnt15");

        send(16'h1001, 4'd5, 1'b0, 4'd15);
        wait_result("sweep_left", 15);
        drain("sweep_left");

        send(16'h00FF, 4'd3, 1'b0, 4'd2);
        wait_result("bp_first", 2);
        in_data  = 16'h0F0F;
        in_amt   = 4'd5;
        in_dir   = 1'b1;
        in_count = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_data", 32'(out_data), 32'(last_exp));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_bubble_in_ready", 32'(in_ready), 32'd1);
        check("bp_bubble_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(rot_model(16'h0F0F, 5, 1'b1, 2));
        check("bp_second_accepted", 32'(busy), 32'd1);
        wait_result("bp_second", 2);
        drain("bp_second");

        send(16'hC0DE, 4'd3, 1'b0, 4'd10);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_data", 32'(out_data), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("arst_release_in_ready", 32'(in_ready), 32'd1);
        send(16'h4321, 4'd9, 1'b1, 4'd2);
        wait_result("after_rst", 2);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
